// File: rtl/icache_fill_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache fill controller.
//   pc_addr, rd_en          : fetch request (byte address, bit0 ignored)
//   instr_out, stall        : instruction word and fetch hold
//   mem_addr, mem_en        : word read request towards main memory
//   mem_data_in, mem_data_valid : in-order memory responses
// Modport slave is the cache; master is the fetch stage / memory environment.
interface icache_fill_ctrl_if;
    logic [15:0] pc_addr;
    logic        rd_en;
    logic [15:0] instr_out;
    logic        stall;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;

    modport slave (
        input  pc_addr, rd_en, mem_data_in, mem_data_valid,
        output instr_out, stall, mem_addr, mem_en
    );

    modport master (
        output pc_addr, rd_en, mem_data_in, mem_data_valid,
        input  instr_out, stall, mem_addr, mem_en
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a block refill FSM.
// Hits return the word combinationally in the same cycle; a miss stalls fetch
// and refills one 8-word block from a fixed-latency pipelined memory.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : icache_fill_ctrl_if.slave (fetch request/response, memory request/response)
//   hit_cnt, miss_cnt : 16-bit saturating statistics, only when ICACHE_STATS_EN is defined
// Parameters: MEM_LAT (memory latency, 1..7), INDEX_W (set index width).
// Configuration macro: ICACHE_STATS_EN.
module icache_fill_ctrl #(
    parameter int unsigned MEM_LAT = 4,
    parameter int unsigned INDEX_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    icache_fill_ctrl_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);
    localparam int unsigned TAG_W    = 12 - INDEX_W;
    localparam int unsigned NUM_SETS = 1 << INDEX_W;
    localparam int unsigned WORDS    = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned ADDR_W   = 16;
    localparam bit          LAT_OK   = (MEM_LAT >= 1) && (MEM_LAT <= 7);

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state;
    logic [CNT_W-1:0]   req_cnt;
    logic [CNT_W-1:0]   rcv_cnt;
    logic [11:0]        fill_blk;          // pc_addr[15:4] of the block being refilled
    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]   tag_arr  [NUM_SETS];
    logic [15:0]        data_arr [NUM_SETS*WORDS];

    logic [2:0]         offset;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               word_in;
    logic               last_word;
    logic               unused_ok;

    assign offset   = bus.pc_addr[3:1];
    assign idx      = bus.pc_addr[4 +: INDEX_W];
    assign tag      = bus.pc_addr[15 -: TAG_W];
    assign fill_idx = fill_blk[INDEX_W-1:0];
    assign fill_tag = fill_blk[11 -: TAG_W];

    assign hit       = bus.rd_en & valid[idx] & (tag_arr[idx] == tag);
    // Responses count only while filling and only for the first 8 words.
    assign word_in   = (state == FILL) & bus.mem_data_valid & (rcv_cnt < CNT_W'(WORDS));
    assign last_word = word_in & (rcv_cnt == CNT_W'(WORDS - 1));

    // Byte-address bit0 and the static latency range check have no logic use.
    assign unused_ok = ^{bus.pc_addr[0], LAT_OK};

    // Control FSM, counters and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_cnt  <= '0;
            rcv_cnt  <= '0;
            fill_blk <= '0;
            valid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_en && !hit) begin
                        state    <= FILL;
                        fill_blk <= bus.pc_addr[15:4];
                        req_cnt  <= '0;
                        rcv_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (req_cnt < CNT_W'(WORDS)) req_cnt <= req_cnt + CNT_W'(1);
                    if (word_in) rcv_cnt <= rcv_cnt + CNT_W'(1);
                    if (last_word) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage; the tag moves only with the last word so a partial block never hits.
    always_ff @(posedge clk) begin
        if (word_in) data_arr[{fill_idx, rcv_cnt[2:0]}] <= bus.mem_data_in;
        if (last_word) tag_arr[fill_idx] <= fill_tag;
    end

    // Combinational outputs from state and storage.
    always_comb begin
        bus.stall     = (state != IDLE) | (bus.rd_en & ~hit);
        bus.instr_out = data_arr[{idx, offset}];
        bus.mem_en    = (state == FILL) & (req_cnt < CNT_W'(WORDS));
        bus.mem_addr  = ADDR_W'({fill_blk, 4'b0000}) + ADDR_W'({req_cnt, 1'b0});
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE) begin
            if (hit && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
            if (bus.rd_en && !hit && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: pipelined memory model, a set-level
// cache model checked every cycle, and directed scenarios with literal expectations.
module tb_icache_fill_ctrl;
    localparam int unsigned L = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic inject_v;
    logic [15:0] inject_d;
    int n_checks = 0;
    int n_pass   = 0;

    icache_fill_ctrl_if bus();

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    icache_fill_ctrl #(.MEM_LAT(L), .INDEX_W(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Main memory contents: a fixed function of the word address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // Fixed-latency in-order memory; shares rst_n and drops its queue on reset.
    logic        pv [L];
    logic [15:0] pa [L];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(L); i++) begin pv[i] <= 1'b0; pa[i] <= '0; end
        end else begin
            pv[0] <= bus.mem_en;
            pa[0] <= bus.mem_addr;
            for (int i = 1; i < int'(L); i++) begin pv[i] <= pv[i-1]; pa[i] <= pa[i-1]; end
        end
    end
    assign bus.mem_data_valid = pv[L-1] | inject_v;
    assign bus.mem_data_in    = inject_v ? inject_d : memf(pa[L-1]);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Cache model: per-set valid/tag, plus a fill timeline counted from the miss cycle.
    bit          mvalid [64];
    bit [5:0]    mtag   [64];
    bit          busy = 1'b0;
    int          t = 0;
    logic [15:0] base = '0;

    always @(negedge clk) begin
        bit mhit, exp_stall, exp_en;
        if (!rst_n) begin
            busy = 1'b0;
            for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        end
        mhit = bus.rd_en && mvalid[bus.pc_addr[9:4]] && (mtag[bus.pc_addr[9:4]] == bus.pc_addr[15:10]);
        exp_stall = busy || (bus.rd_en && !mhit);
        exp_en = busy && (t <= 8);
        chk("model_stall", 16'(bus.stall), 16'(exp_stall));
        chk("model_mem_en", 16'(bus.mem_en), 16'(exp_en));
        if (exp_en) chk("model_mem_addr", bus.mem_addr, base + 16'(2 * (t - 1)));
        if (bus.rd_en && !exp_stall)
            chk("model_instr", bus.instr_out, memf({bus.pc_addr[15:1], 1'b0}));
        if (rst_n) begin
            if (busy) begin
                if (t == 8 + int'(L)) begin
                    mvalid[base[9:4]] = 1'b1;
                    mtag[base[9:4]]   = base[15:10];
                    busy = 1'b0;
                end else t++;
            end else if (bus.rd_en && !mhit) begin
                busy = 1'b1;
                t    = 1;
                base = {bus.pc_addr[15:4], 4'b0000};
            end
        end
    end

    // Count stalled cycles and request cycles until stall drops, then capture the word.
    task automatic wait_drop(output int sc, output int ec, output logic [15:0] d);
        bit done;
        done = 1'b0; sc = 0; ec = 0; d = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.mem_en) ec++;
            if (!bus.stall) begin d = bus.instr_out; done = 1'b1; end
            else sc++;
        end
        if (!done) chk("stall_timeout", 16'(bus.stall), 16'h0);
    endtask

    task automatic access(input logic [15:0] a, output int sc, output int ec, output logic [15:0] d);
        @(posedge clk); #1;
        bus.pc_addr = a;
        bus.rd_en   = 1'b1;
        wait_drop(sc, ec, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; bus.rd_en = 1'b0; end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst_n = 1'b0; bus.rd_en = 1'b0;
        @(negedge clk);
        chk("rst_stall", 16'(bus.stall), 16'h0);
        chk("rst_mem_en", 16'(bus.mem_en), 16'h0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int sc, ec, sc0, ec0;
        logic [15:0] d;
        rst_n = 1'b0; bus.rd_en = 1'b0; bus.pc_addr = '0; inject_v = 1'b0; inject_d = '0;
        @(negedge clk);
        chk("init_stall", 16'(bus.stall), 16'h0);
        chk("init_mem_en", 16'(bus.mem_en), 16'h0);
        chk("init_mem_addr", bus.mem_addr, 16'h0000);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(2);

        // Cold miss on 0x0000.
        access(16'h0000, sc, ec, d);
        chk("t1_stall_cycles", 16'(sc), 16'd13);
        chk("t1_req_cycles", 16'(ec), 16'd8);
        chk("t1_instr", d, 16'h5A5A);

        // Rest of the block hits with no memory traffic.
        for (int a = 2; a <= 14; a += 2) begin
            access(16'(a), sc, ec, d);
            chk("t2_stall_cycles", 16'(sc), 16'd0);
            chk("t2_req_cycles", 16'(ec), 16'd0);
            chk("t2_instr", d, memf(16'(a)));
        end
        chk("t2_last_instr", d, 16'h545A);
        idle(1);
`ifdef ICACHE_STATS_EN
        chk("stats_miss_cnt", miss_cnt, 16'd1);
        chk("stats_hit_cnt", hit_cnt, 16'd8);
`endif

        // Conflict miss and eviction in set 0.
        access(16'h0400, sc, ec, d);
        chk("t3_conf_stall", 16'(sc), 16'd13);
        chk("t3_conf_instr", d, 16'h5A5E);
        access(16'h0000, sc, ec, d);
        chk("t3_evict_stall", 16'(sc), 16'd13);
        chk("t3_evict_instr", d, 16'h5A5A);
        access(16'h0000, sc, ec, d);
        chk("t3_rehit_stall", 16'(sc), 16'd0);
        idle(1);

        // Stray responses while idle must not disturb the stored block.
        @(posedge clk); #1; inject_v = 1'b1; inject_d = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1; inject_v = 1'b0;
        for (int a = 0; a <= 14; a += 2) begin
            access(16'(a), sc, ec, d);
            chk("stray_stall", 16'(sc), 16'd0);
        end
        chk("stray_instr", d, 16'h545A);
        idle(1);

        // Clean reset invalidates everything; no fetch means no stall.
        reset_pulse();
        bus.pc_addr = 16'h0100;
        @(negedge clk);
        chk("t4_noreq_stall", 16'(bus.stall), 16'h0);
        chk("t4_noreq_mem_en", 16'(bus.mem_en), 16'h0);

        // PC moves during a fill: old block completes, then the new PC misses.
        @(posedge clk); #1; bus.pc_addr = 16'h0000; bus.rd_en = 1'b1;
        sc0 = 0; ec0 = 0;
        repeat (3) begin
            @(negedge clk);
            sc0 += int'(bus.stall);
            ec0 += int'(bus.mem_en);
        end
        @(posedge clk); #1; bus.pc_addr = 16'h0020;
        wait_drop(sc, ec, d);
        chk("t4_switch_stall", 16'(sc + sc0), 16'd26);
        chk("t4_switch_reqs", 16'(ec + ec0), 16'd16);
        chk("t4_switch_instr", d, 16'h7A5A);
        access(16'h0000, sc, ec, d);
        chk("t4_old_block_hit", 16'(sc), 16'd0);
        chk("t4_old_block_instr", d, 16'h5A5A);
        idle(1);

        // Reset in cycle 6 of a fill.
        @(posedge clk); #1; bus.pc_addr = 16'h0080; bus.rd_en = 1'b1;
        repeat (6) @(posedge clk);
        #1; rst_n = 1'b0; bus.rd_en = 1'b0;
        @(negedge clk);
        chk("t5_rst_mem_en", 16'(bus.mem_en), 16'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("t5_after_stall", 16'(bus.stall), 16'h0);
        chk("t5_after_mem_en", 16'(bus.mem_en), 16'h0);
        access(16'h0000, sc, ec, d);
        chk("t5_refill_stall", 16'(sc), 16'd13);
        chk("t5_refill_instr", d, 16'h5A5A);
        access(16'h0080, sc, ec, d);
        chk("t5_aborted_stall", 16'(sc), 16'd13);
        chk("t5_aborted_instr", d, memf(16'h0080));
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
